// File: rtl/duckhunt_pkg.sv
// Shared definitions for the duck-hunt shot judge: state encoding, sprite and screen geometry.
package duckhunt_pkg;

  typedef enum logic [2:0] {
    S_ACTIVE,
    S_FALL,
    S_FLY,
    S_NEXT,
    S_OVER
  } state_t;

  localparam int unsigned SPRITE_SIZE = 16;
  localparam int unsigned X_W         = 8;
  localparam int unsigned Y_W         = 7;

  localparam logic [1:0] AMMO_MAX = 2'd3;

endpackage

// File: rtl/hitbox_cmp.sv
// Combinational test of whether the crosshair top-left pixel lies inside the bird sprite box.
module hitbox_cmp
  import duckhunt_pkg::*;
(
  input  logic [X_W-1:0] p_x,
  input  logic [Y_W-1:0] p_y,
  input  logic [X_W-1:0] b_x,
  input  logic [Y_W-1:0] b_y,
  output logic           hit
);

  // One extra bit on the far edges so a bird near the right/bottom border does not wrap.
  logic [X_W:0] x_far;
  logic [Y_W:0] y_far;

  assign x_far = {1'b0, b_x} + (X_W + 1)'(SPRITE_SIZE - 1);
  assign y_far = {1'b0, b_y} + (Y_W + 1)'(SPRITE_SIZE - 1);

  assign hit = (p_x >= b_x) && ({1'b0, p_x} <= x_far) &&
               (p_y >= b_y) && ({1'b0, p_y} <= y_far);

endmodule

// File: rtl/shot_judge.sv
// Judges shots against the current bird, tracks ammo/hits/score/round and sequences ducks.
// Optional end-of-round perfect bonus is enabled by defining SHOT_JUDGE_BONUS_EN.
module shot_judge
  import duckhunt_pkg::*;
#(
  parameter int unsigned ESCAPE_TICKS    = 256,
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned HITS_TO_PASS    = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           tick,
  input  logic           trigger,
  input  logic [X_W-1:0] p_x,
  input  logic [Y_W-1:0] p_y,
  input  logic [X_W-1:0] b_x,
  input  logic [Y_W-1:0] b_y,
  input  logic           bird_gone,
  output logic           is_shot,
  output logic           escape,
  output logic           out_of_ammo,
  output logic           leave,
  output logic           game_over,
  output logic [3:0]     round,
  output logic [1:0]     ammo,
  output logic [3:0]     hits,
  output logic [7:0]     score
);

  localparam logic [8:0] ESC_LIMIT  = 9'(ESCAPE_TICKS);
  localparam logic [3:0] DUCKS_LAST = 4'(DUCKS_PER_ROUND);
  localparam logic [3:0] HITS_MIN   = 4'(HITS_TO_PASS);

  state_t     state_q;
  logic       trig_q;
  logic [8:0] timer_q;
  logic [3:0] ducks_q;
  logic       hit;
  logic       shot;
  logic [8:0] hit_score;
  logic [8:0] timer_inc;
  logic [3:0] ducks_inc;

  hitbox_cmp u_hitbox (
    .p_x (p_x),
    .p_y (p_y),
    .b_x (b_x),
    .b_y (b_y),
    .hit (hit)
  );

  // Empty gun never counts as a shot, so the tick path still runs that cycle.
  assign shot      = trigger & ~trig_q & (ammo != 2'd0);
  assign hit_score = {1'b0, score} + {5'd0, round} + 9'd1;
  assign timer_inc = timer_q + 9'd1;
  assign ducks_inc = ducks_q + 4'd1;

`ifdef SHOT_JUDGE_BONUS_EN
  logic [8:0] bonus_score;
  assign bonus_score = {1'b0, score} + 9'd10;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_ACTIVE;
      trig_q      <= 1'b0;
      timer_q     <= '0;
      ducks_q     <= '0;
      is_shot     <= 1'b0;
      escape      <= 1'b0;
      out_of_ammo <= 1'b0;
      leave       <= 1'b0;
      game_over   <= 1'b0;
      round       <= 4'd1;
      ammo        <= AMMO_MAX;
      hits        <= '0;
      score       <= '0;
    end else begin
      trig_q <= trigger;
      unique case (state_q)
        S_ACTIVE: begin
          // A shot owns the cycle; a coincident tick (even the expiring one) is dropped.
          if (shot) begin
            ammo <= ammo - 2'd1;
            if (hit) begin
              is_shot <= 1'b1;
              if (hits < DUCKS_LAST) hits <= hits + 4'd1;
              score   <= hit_score[8] ? 8'hFF : hit_score[7:0];
              state_q <= S_FALL;
            end else if (ammo == 2'd1) begin
              out_of_ammo <= 1'b1;
              escape      <= 1'b1;
              state_q     <= S_FLY;
            end
          end else if (tick) begin
            timer_q <= timer_inc;
            if (timer_inc == ESC_LIMIT) begin
              escape  <= 1'b1;
              state_q <= S_FLY;
            end
          end
        end
        S_FALL, S_FLY: begin
          if (bird_gone) begin
            leave   <= 1'b1;
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          leave       <= 1'b0;
          is_shot     <= 1'b0;
          escape      <= 1'b0;
          out_of_ammo <= 1'b0;
          timer_q     <= '0;
          ammo        <= AMMO_MAX;
          ducks_q     <= ducks_inc;
          state_q     <= S_ACTIVE;
          if (ducks_inc == DUCKS_LAST) begin
            if (hits >= HITS_MIN) begin
              if (round != 4'hF) round <= round + 4'd1;
              hits    <= '0;
              ducks_q <= '0;
            end else begin
              game_over <= 1'b1;
              state_q   <= S_OVER;
            end
`ifdef SHOT_JUDGE_BONUS_EN
            if (hits == DUCKS_LAST) score <= bonus_score[8] ? 8'hFF : bonus_score[7:0];
`endif
          end
        end
        S_OVER: game_over <= 1'b1;
        default: state_q <= S_ACTIVE;
      endcase
    end
  end

endmodule
